// File: rtl/pdm_capture_ctrl.sv
// PDM microphone capture: micClk generation, ones-count decimation with a
// start-up warm-up phase, and a first-word-fall-through output FIFO.
module pdm_capture_ctrl #(
  parameter int unsigned CLK_DIV        = 34,
  parameter int unsigned DECIM          = 64,
  parameter int unsigned WARMUP_WINDOWS = 4,
  parameter int unsigned FIFO_DEPTH     = 16,
  localparam int unsigned PCM_W         = $clog2(DECIM) + 1,
  localparam int unsigned LVL_W         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk_100MHz,
  input  logic             sysreset,
  input  logic             en,
  input  logic             mic_data,
  output logic             mic_clk,
  output logic [PCM_W-1:0] pcm_data,
  output logic             pcm_valid,
  input  logic             pcm_ready,
  output logic [LVL_W-1:0] fifo_level,
  output logic             overflow,
  input  logic             clr_ovf,
  output logic             busy
);

  localparam int unsigned DIV_W  = $clog2(CLK_DIV);
  localparam int unsigned HALF   = CLK_DIV / 2;
  localparam int unsigned SAMP_W = $clog2(DECIM);
  localparam int unsigned WARM_W = $clog2(WARMUP_WINDOWS + 1);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WARMUP  = 2'd1,
    CAPTURE = 2'd2,
    STOP    = 2'd3
  } state_t;

  state_t state;
  state_t nextState;

  logic [DIV_W-1:0]  divCnt;
  logic [DIV_W-1:0]  nextDivCnt;
  logic [SAMP_W-1:0] sampleCnt;
  logic [SAMP_W-1:0] nextSampleCnt;
  logic [PCM_W-1:0]  onesCnt;
  logic [PCM_W-1:0]  nextOnesCnt;
  logic [WARM_W-1:0] warmCnt;
  logic [WARM_W-1:0] nextWarmCnt;

  logic              strobe;
  logic              windowDone;
  logic [PCM_W-1:0]  wordVal;
  logic              pushReq;

  logic [PCM_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rdPtr;
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  nextRdPtr;
  logic [PTR_W-1:0]  nextWrPtr;
  logic [LVL_W-1:0]  nextLevel;
  logic [PCM_W-1:0]  nextHead;
  logic              popReq;
  logic              fifoFull;
  logic              pushOk;
  logic              dropWord;

  // State register
  always_ff @(posedge clk_100MHz or posedge sysreset) begin
    if (sysreset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Divider, strobe, window accumulation and state transitions
  always_comb begin
    nextState     = state;
    nextDivCnt    = '0;
    nextSampleCnt = sampleCnt;
    nextOnesCnt   = onesCnt;
    nextWarmCnt   = warmCnt;
    strobe        = 1'b0;
    windowDone    = 1'b0;
    wordVal       = '0;
    pushReq       = 1'b0;

    if (state != IDLE) begin
      strobe     = (divCnt == DIV_W'(HALF - 1));
      nextDivCnt = (divCnt == DIV_W'(CLK_DIV - 1)) ? '0 : divCnt + DIV_W'(1);
    end

    if (strobe) begin
      if (sampleCnt == SAMP_W'(DECIM - 1)) begin
        windowDone    = 1'b1;
        wordVal       = onesCnt + PCM_W'(mic_data);
        nextSampleCnt = '0;
        nextOnesCnt   = '0;
      end else begin
        nextSampleCnt = sampleCnt + SAMP_W'(1);
        nextOnesCnt   = onesCnt + PCM_W'(mic_data);
      end
    end

    case (state)
      IDLE: begin
        if (en) nextState = WARMUP;
      end
      WARMUP: begin
        if (!en) begin
          nextState = IDLE;
        end else if (windowDone) begin
          if (warmCnt == WARM_W'(WARMUP_WINDOWS - 1)) begin
            nextState   = CAPTURE;
            nextWarmCnt = '0;
          end else begin
            nextWarmCnt = warmCnt + WARM_W'(1);
          end
        end
      end
      CAPTURE: begin
        pushReq = windowDone;
        // Stopping on a window boundary has nothing left to finish
        if (!en) nextState = (nextSampleCnt == '0) ? IDLE : STOP;
      end
      STOP: begin
        pushReq = windowDone;
        if (windowDone) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase

    // Every exit to IDLE discards partial progress
    if (nextState == IDLE) begin
      nextDivCnt    = '0;
      nextSampleCnt = '0;
      nextOnesCnt   = '0;
      nextWarmCnt   = '0;
    end
  end

  // Capture counters and registered mic clock / busy
  always_ff @(posedge clk_100MHz or posedge sysreset) begin
    if (sysreset) begin
      divCnt    <= '0;
      sampleCnt <= '0;
      onesCnt   <= '0;
      warmCnt   <= '0;
      mic_clk   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      divCnt    <= nextDivCnt;
      sampleCnt <= nextSampleCnt;
      onesCnt   <= nextOnesCnt;
      warmCnt   <= nextWarmCnt;
      mic_clk   <= (nextState != IDLE) && (nextDivCnt < DIV_W'(HALF));
      busy      <= (nextState != IDLE);
    end
  end

  // FIFO push/pop decisions and next head word
  always_comb begin
    popReq    = pcm_valid && pcm_ready;
    fifoFull  = (fifo_level == LVL_W'(FIFO_DEPTH));
    pushOk    = pushReq && (!fifoFull || popReq);
    dropWord  = pushReq && fifoFull && !popReq;
    nextRdPtr = rdPtr + PTR_W'(popReq);
    nextWrPtr = wrPtr + PTR_W'(pushOk);
    nextLevel = fifo_level;
    if (pushOk && !popReq) begin
      nextLevel = fifo_level + LVL_W'(1);
    end else if (!pushOk && popReq) begin
      nextLevel = fifo_level - LVL_W'(1);
    end
    // A word written this edge into the new head slot bypasses the array
    if (nextLevel == '0) begin
      nextHead = '0;
    end else if (pushOk && (nextRdPtr == wrPtr)) begin
      nextHead = wordVal;
    end else begin
      nextHead = mem[nextRdPtr];
    end
  end

  // FIFO storage
  always_ff @(posedge clk_100MHz) begin
    if (pushOk) mem[wrPtr] <= wordVal;
  end

  // FIFO pointers, level, registered head and sticky overflow
  always_ff @(posedge clk_100MHz or posedge sysreset) begin
    if (sysreset) begin
      rdPtr      <= '0;
      wrPtr      <= '0;
      fifo_level <= '0;
      pcm_data   <= '0;
      pcm_valid  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      rdPtr      <= nextRdPtr;
      wrPtr      <= nextWrPtr;
      fifo_level <= nextLevel;
      pcm_data   <= nextHead;
      pcm_valid  <= (nextLevel != '0);
      if (dropWord) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// Scoreboard bench for pdm_capture_ctrl at default parameters.
module tb_pdm_capture_ctrl;

  localparam int unsigned PCM_W = 7;
  localparam int unsigned LVL_W = 5;
  localparam int WIN = 64;

  logic             clk_100MHz = 1'b0;
  logic             sysreset   = 1'b1;
  logic             en         = 1'b0;
  logic             mic_data   = 1'b0;
  logic             pcm_ready  = 1'b0;
  logic             clr_ovf    = 1'b0;
  logic             mic_clk;
  logic [PCM_W-1:0] pcm_data;
  logic             pcm_valid;
  logic [LVL_W-1:0] fifo_level;
  logic             overflow;
  logic             busy;

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int popCount  = 0;
  int strobeCnt = 0;
  int mode      = 0;
  logic prevMicClk = 1'b0;
  logic fell;
  int expQ[$];

  pdm_capture_ctrl dut (
    .clk_100MHz(clk_100MHz),
    .sysreset  (sysreset),
    .en        (en),
    .mic_data  (mic_data),
    .mic_clk   (mic_clk),
    .pcm_data  (pcm_data),
    .pcm_valid (pcm_valid),
    .pcm_ready (pcm_ready),
    .fifo_level(fifo_level),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf),
    .busy      (busy)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  always @(posedge clk_100MHz) cyc++;

  task automatic checkEq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Ones per window for the per-window pattern mode
  function automatic int winOnes(input int w);
    return (w * 7 + 3) % 65;
  endfunction

  // mic_data source; strobes counted from the mic_clk falling edge after each sample
  always @(posedge clk_100MHz) begin
    #1;
    fell = prevMicClk && !mic_clk;
    if (!busy) strobeCnt = 0;
    else if (fell) strobeCnt++;
    prevMicClk = mic_clk;
    case (mode)
      0: mic_data = 1'b0;
      1: mic_data = 1'b1;
      2: if (fell) mic_data = ~mic_data;
      default: mic_data = ((strobeCnt % WIN) < winOnes(strobeCnt / WIN));
    endcase
  end

  // Scoreboard: every accepted word is compared with the oldest expectation
  always @(negedge clk_100MHz) begin
    if (!sysreset && pcm_valid && pcm_ready) begin
      checkEq("word_pending", int'(expQ.size() > 0), 1);
      if (expQ.size() > 0) checkEq("pcm_word", int'(pcm_data), expQ.pop_front());
      popCount++;
    end
  end

  task automatic cycStart();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic midCyc();
    @(negedge clk_100MHz);
  endtask

  task automatic waitPops(input int target, input int budget, input string tag);
    int n = 0;
    while (popCount < target && n < budget) begin
      midCyc();
      n++;
    end
    checkEq(tag, popCount, target);
  endtask

  task automatic waitStrobes(input int target, input int budget, input string tag);
    int n = 0;
    while (strobeCnt < target && n < budget) begin
      midCyc();
      n++;
    end
    checkEq(tag, strobeCnt, target);
  endtask

  // Returns cycle (relative to en) where pcm_valid first rises; also mic_clk shape
  task automatic runToFirstWord(input int startCyc, output int firstRise,
                                output int firstFall, output int secondRise,
                                output int validAt);
    logic prev = 1'b0;
    int rel;
    firstRise = -1; firstFall = -1; secondRise = -1; validAt = -1;
    for (int n = 0; n < 12000 && validAt < 0; n++) begin
      midCyc();
      rel = cyc - startCyc;
      if (mic_clk && !prev) begin
        if (firstRise < 0) firstRise = rel;
        else if (secondRise < 0) secondRise = rel;
      end
      if (!mic_clk && prev && firstFall < 0) firstFall = rel;
      prev = mic_clk;
      if (pcm_valid) validAt = rel;
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int startCyc, r1, f1, r2, vAt;
    bit sawValid;

    // Reset values
    repeat (3) midCyc();
    checkEq("rst_mic_clk", int'(mic_clk), 0);
    checkEq("rst_pcm_valid", int'(pcm_valid), 0);
    checkEq("rst_pcm_data", int'(pcm_data), 0);
    checkEq("rst_fifo_level", int'(fifo_level), 0);
    checkEq("rst_overflow", int'(overflow), 0);
    checkEq("rst_busy", int'(busy), 0);
    cycStart();
    sysreset = 1'b0;
    repeat (4) cycStart();
    midCyc();
    checkEq("idle_mic_clk", int'(mic_clk), 0);
    checkEq("idle_busy", int'(busy), 0);

    // All-ones input: timing of mic_clk and first word
    cycStart();
    expQ.push_back(64);
    mode = 1; pcm_ready = 1'b1; en = 1'b1;
    startCyc = cyc;
    runToFirstWord(startCyc, r1, f1, r2, vAt);
    checkEq("mic_clk_first_rise", r1, 1);
    checkEq("mic_clk_high_len", f1 - r1, 17);
    checkEq("mic_clk_period", r2 - r1, 34);
    checkEq("first_valid_cycle", vAt, 10864);
    checkEq("busy_capture", int'(busy), 1);
    waitPops(1, 50, "pop_word1");

    // Alternating input, then all zeros
    cycStart();
    mode = 2; expQ.push_back(32);
    waitPops(2, 2500, "pop_toggle");
    cycStart();
    mode = 0; expQ.push_back(0);
    waitPops(3, 2500, "pop_zero");

    // Back-pressure: 16 words fill the FIFO, the 17th and 18th are dropped
    cycStart();
    pcm_ready = 1'b0; mode = 3;
    for (int w = 7; w <= 22; w++) expQ.push_back(winOnes(w));
    waitStrobes(23 * WIN, 16 * 2176 + 200, "fill_wait");
    checkEq("full_level", int'(fifo_level), 16);
    checkEq("full_no_ovf", int'(overflow), 0);
    checkEq("full_valid", int'(pcm_valid), 1);
    checkEq("full_head", int'(pcm_data), winOnes(7));
    waitStrobes(24 * WIN, 2300, "ovf_wait");
    checkEq("ovf_after_17", int'(overflow), 1);
    checkEq("ovf_level", int'(fifo_level), 16);
    waitStrobes(25 * WIN, 2300, "ovf2_wait");
    checkEq("ovf_sticky", int'(overflow), 1);
    checkEq("ovf2_level", int'(fifo_level), 16);
    cycStart();
    clr_ovf = 1'b1;
    cycStart();
    clr_ovf = 1'b0;
    midCyc();
    checkEq("ovf_cleared", int'(overflow), 0);

    // Drain 11 words in order, leaving 5 held
    cycStart();
    pcm_ready = 1'b1;
    repeat (10) cycStart();
    cycStart();
    pcm_ready = 1'b0;
    midCyc();
    checkEq("drain_pops", popCount, 14);
    checkEq("drain_level", int'(fifo_level), 5);
    checkEq("drain_busy", int'(busy), 1);

    // Asynchronous reset mid-capture with 5 words held
    @(negedge clk_100MHz);
    #2 sysreset = 1'b1;
    #1;
    checkEq("arst_mic_clk", int'(mic_clk), 0);
    checkEq("arst_pcm_valid", int'(pcm_valid), 0);
    checkEq("arst_pcm_data", int'(pcm_data), 0);
    checkEq("arst_fifo_level", int'(fifo_level), 0);
    checkEq("arst_overflow", int'(overflow), 0);
    checkEq("arst_busy", int'(busy), 0);
    expQ.delete();
    en = 1'b0; mode = 1;
    repeat (2) cycStart();
    sysreset = 1'b0;
    midCyc();
    checkEq("post_rst_level", int'(fifo_level), 0);

    // Restart reproduces first-word timing
    cycStart();
    expQ.push_back(64);
    pcm_ready = 1'b1; en = 1'b1;
    startCyc = cyc;
    runToFirstWord(startCyc, r1, f1, r2, vAt);
    checkEq("restart_valid_cycle", vAt, 10864);
    checkEq("restart_period", r2 - r1, 34);
    waitPops(15, 50, "pop_restart");

    // en drops halfway through a capture window: exactly one more word
    waitStrobes(5 * WIN + 32, 2500, "half_wait");
    cycStart();
    en = 1'b0; expQ.push_back(64);
    sawValid = 1'b0;
    for (int n = 0; n < 2500 && !sawValid; n++) begin
      midCyc();
      sawValid = pcm_valid;
    end
    checkEq("stop_word_seen", int'(sawValid), 1);
    checkEq("stop_busy", int'(busy), 0);
    checkEq("stop_mic_clk", int'(mic_clk), 0);
    repeat (300) midCyc();
    checkEq("stop_pops", popCount, 16);
    checkEq("stop_level", int'(fifo_level), 0);

    // en drops during warm-up: abort with no word
    cycStart();
    en = 1'b1;
    repeat (1000) cycStart();
    en = 1'b0;
    midCyc();
    checkEq("abort_busy_before", int'(busy), 1);
    midCyc();
    checkEq("abort_busy", int'(busy), 0);
    checkEq("abort_mic_clk", int'(mic_clk), 0);
    sawValid = 1'b0;
    repeat (500) begin
      midCyc();
      if (pcm_valid) sawValid = 1'b1;
    end
    checkEq("abort_no_word", int'(sawValid), 0);
    checkEq("abort_pops", popCount, 16);

    checkEq("queue_drained", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
